// File: rtl/apb_mem_completer_if.sv
// APB4 bus bundle between the DMA's APB initiator (master) and apb_mem_completer (slave).
interface apb_mem_completer_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 12
);
   logic                    i_psel;
   logic                    i_penable;
   logic                    i_pwrite;
   logic [ADDR_WIDTH-1:0]   i_paddr;
   logic [DATA_WIDTH-1:0]   i_pwdata;
   logic [DATA_WIDTH/8-1:0] i_pstrb;
   logic                    o_pready;
   logic [DATA_WIDTH-1:0]   o_prdata;
   logic                    o_pslverr;
   logic                    o_prot_err;
   logic [CNT_WIDTH-1:0]    o_xfer_cnt;

   modport master (
      output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
      input  o_pready, o_prdata, o_pslverr, o_prot_err, o_xfer_cnt
   );

   modport slave (
      input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
      output o_pready, o_prdata, o_pslverr, o_prot_err, o_xfer_cnt
   );
endinterface

// File: rtl/apb_mem_completer.sv
// APB4 completer backed by a word-addressed RAM with registered response and a completion counter.
// Optional wait states: define APB_COMPLETER_WAIT_EN to insert WAIT_CYCLES wait states per access.
module apb_mem_completer #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic                _clk,
   input logic                _nreset,
   apb_mem_completer_if.slave bus
);
   localparam int unsigned CNT_W = 12;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned NLANE = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * 4);
`ifdef APB_COMPLETER_WAIT_EN
   localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam int unsigned WCNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
`else
   localparam bit          ZERO_WAIT = 1'b1;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NLANE-1:0]        strb_q, strb_d;
   logic                    pready_q, pready_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    pslverr_q, pslverr_d;
   logic                    prot_err_q, prot_err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
`ifdef APB_COMPLETER_WAIT_EN
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
`endif
   logic                    ram_we_c;
   logic [ADDR_WIDTH-1:0]   rsp_addr_c;
   logic                    rsp_wr_c;
   logic                    rsp_err_c;
   logic [DATA_WIDTH-1:0]   rsp_data_c;

   logic [DATA_WIDTH-1:0]   ram_q [DEPTH] = '{default: '0};

   // In IDLE the response is built from the address being latched; afterwards from the latched copy.
   assign rsp_addr_c = (state_q == S_IDLE) ? bus.i_paddr  : addr_q;
   assign rsp_wr_c   = (state_q == S_IDLE) ? bus.i_pwrite : write_q;
   assign rsp_err_c  = (rsp_addr_c[1:0] != 2'b00) || ({1'b0, rsp_addr_c} >= ADDR_LIMIT);
   assign rsp_data_c = (rsp_wr_c || rsp_err_c) ? '0 : ram_q[rsp_addr_c[IDX_W+1:2]];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      pready_d   = 1'b0;
      prdata_d   = '0;
      pslverr_d  = 1'b0;
      prot_err_d = 1'b0;
      cnt_d      = cnt_q;
      ram_we_c   = 1'b0;
`ifdef APB_COMPLETER_WAIT_EN
      wcnt_d     = wcnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_psel && !bus.i_penable) begin
               addr_d  = bus.i_paddr;
               write_d = bus.i_pwrite;
               wdata_d = bus.i_pwdata;
               strb_d  = bus.i_pstrb;
               if (ZERO_WAIT) begin
                  state_d   = S_READY;
                  pready_d  = 1'b1;
                  pslverr_d = rsp_err_c;
                  prdata_d  = rsp_data_c;
               end
`ifdef APB_COMPLETER_WAIT_EN
               else begin
                  state_d = S_WAIT;
                  wcnt_d  = WCNT_W'(WAIT_CYCLES);
               end
`endif
            end else if (bus.i_psel && bus.i_penable) begin
               prot_err_d = 1'b1;
            end
         end
`ifdef APB_COMPLETER_WAIT_EN
         S_WAIT: begin
            if (!bus.i_psel) begin
               state_d = S_IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_W'(1)) begin
               state_d   = S_READY;
               wcnt_d    = '0;
               pready_d  = 1'b1;
               pslverr_d = rsp_err_c;
               prdata_d  = rsp_data_c;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
`endif
         S_READY: begin
            state_d = S_IDLE;
            if (!rsp_err_c) begin
               ram_we_c = write_q;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge _clk or negedge _nreset) begin
      if (!_nreset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
         prot_err_q <= 1'b0;
         cnt_q      <= '0;
`ifdef APB_COMPLETER_WAIT_EN
         wcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
         prot_err_q <= prot_err_d;
         cnt_q      <= cnt_d;
`ifdef APB_COMPLETER_WAIT_EN
         wcnt_q     <= wcnt_d;
`endif
      end
   end

   // RAM contents survive reset; byte-lane write at the edge closing the READY cycle.
   always_ff @(posedge _clk) begin
      if (ram_we_c) begin
         for (int b = 0; b < NLANE; b++) begin
            if (strb_q[b]) begin
               ram_q[addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign bus.o_pready   = pready_q;
   assign bus.o_prdata   = prdata_q;
   assign bus.o_pslverr  = pslverr_q;
   assign bus.o_prot_err = prot_err_q;
   assign bus.o_xfer_cnt = cnt_q;
endmodule

// File: tb/tb_apb_mem_completer.sv
// Self-checking bench for apb_mem_completer: directed table, corner sequences, random traffic vs. a word-array model.
module tb_apb_mem_completer;
   localparam int unsigned AW       = 12;
   localparam int unsigned DW       = 32;
   localparam int unsigned DEPTH    = 256;
   localparam int unsigned WAIT_CFG = 3;
`ifdef APB_COMPLETER_WAIT_EN
   localparam int unsigned EXP_W = WAIT_CFG;
`else
   localparam int unsigned EXP_W = 0;
`endif
   localparam int MAXLAT = 32;
   localparam int NTBL   = 11;

   logic _clk = 1'b0;
   logic _nreset = 1'b0;
   always #5 _clk = ~_clk;

   apb_mem_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(12)) bus ();

   apb_mem_completer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CFG)
   ) dut (
      ._clk(_clk),
      ._nreset(_nreset),
      .bus(bus)
   );

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [31:0] exp_rd;
      bit          exp_er;
      int          exp_cnt;
   } vec_t;

   vec_t        tbl [NTBL];
   logic [31:0] mdl_mem [DEPTH];
   int          mdl_cnt;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic step();
      @(posedge _clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: word array plus wrap-around completion counter.
   task automatic model(input bit wr, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] exp_rd, output bit exp_er);
      int idx;
      exp_er = (a % 4 != 0) || (a >= DEPTH * 4);
      exp_rd = '0;
      idx    = a / 4;
      if (!exp_er) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (st[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
         end else begin
            exp_rd = mdl_mem[idx];
         end
         mdl_cnt = (mdl_cnt + 1) % 4096;
      end
   endtask

   // One APB transfer; optionally scrambles non-psel inputs during ACCESS.
   task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input bit scramble, output logic [31:0] rd, output bit er, output int lat);
      bus.i_psel    = 1'b1;
      bus.i_penable = 1'b0;
      bus.i_pwrite  = wr;
      bus.i_paddr   = a;
      bus.i_pwdata  = wd;
      bus.i_pstrb   = st;
      step();
      bus.i_penable = 1'b1;
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      for (int k = 1; k <= MAXLAT; k++) begin
         if (scramble) begin
            bus.i_paddr  = 12'($urandom);
            bus.i_pwdata = $urandom;
            bus.i_pstrb  = 4'($urandom);
            bus.i_pwrite = 1'($urandom);
         end
         if (bus.o_pready) begin
            lat = k;
            rd  = bus.o_prdata;
            er  = bus.o_pslverr;
            break;
         end
         step();
      end
      step();
      bus.i_psel    = 1'b0;
      bus.i_penable = 1'b0;
      chk("pready_one_cycle", 32'(bus.o_pready), 32'd0);
   endtask

   task automatic run(input string nm, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit scr,
                      input logic [31:0] exp_rd, input bit exp_er, input int exp_cnt);
      logic [31:0] rd;
      bit          er;
      int          lat;
      xfer(wr, a, wd, st, scr, rd, er, lat);
      chk({nm, "_latency"}, 32'(lat), 32'(EXP_W + 1));
      chk({nm, "_prdata"},  rd, exp_rd);
      chk({nm, "_pslverr"}, 32'(er), 32'(exp_er));
      chk({nm, "_xfer_cnt"}, 32'(bus.o_xfer_cnt), 32'(exp_cnt));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] erd;
      bit          eer;
      bit          wr;
      logic [11:0] a;
      int          sel;
      int          seen;

      tbl[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1};
      tbl[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2};
      tbl[2]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0,        1'b0, 3};
      tbl[3]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 4};
      tbl[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 5};
      tbl[5]  = '{1'b0, 12'h002, 32'h0,        4'h0, 32'h0,        1'b1, 5};
      tbl[6]  = '{1'b0, 12'h400, 32'h0,        4'h0, 32'h0,        1'b1, 5};
      tbl[7]  = '{1'b1, 12'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 6};
      tbl[8]  = '{1'b1, 12'h3FE, 32'h12345678, 4'hF, 32'h0,        1'b1, 6};
      tbl[9]  = '{1'b0, 12'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 7};
      tbl[10] = '{1'b1, 12'hFFC, 32'h55555555, 4'hF, 32'h0,        1'b1, 7};

      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      mdl_cnt = 0;

      bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0;
      bus.i_paddr = '0;  bus.i_pwdata = '0;    bus.i_pstrb = '0;

      // Reset state
      step(); step();
      chk("rst_pready",   32'(bus.o_pready),   32'd0);
      chk("rst_prdata",   bus.o_prdata,        32'd0);
      chk("rst_pslverr",  32'(bus.o_pslverr),  32'd0);
      chk("rst_prot_err", 32'(bus.o_prot_err), 32'd0);
      chk("rst_xfer_cnt", 32'(bus.o_xfer_cnt), 32'd0);
      _nreset = 1'b1;
      step();

      // Directed table
      for (int i = 0; i < NTBL; i++) begin
         model(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].st, erd, eer);
         run($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].st, 1'b0,
             tbl[i].exp_rd, tbl[i].exp_er, tbl[i].exp_cnt);
      end

      // ACCESS without SETUP
      bus.i_psel = 1'b1; bus.i_penable = 1'b1;
      step();
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      chk("prot_err_pulse",  32'(bus.o_prot_err), 32'd1);
      chk("prot_err_pready", 32'(bus.o_pready),   32'd0);
      step();
      chk("prot_err_clear",  32'(bus.o_prot_err), 32'd0);
      chk("prot_err_cnt",    32'(bus.o_xfer_cnt), 32'(mdl_cnt));

`ifdef APB_COMPLETER_WAIT_EN
      // Abort: psel dropped in access cycle 2 of a wait-state write
      bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
      bus.i_paddr = 12'h060; bus.i_pwdata = 32'hA5A55A5A; bus.i_pstrb = 4'hF;
      seen = 0;
      step();
      if (bus.o_pready) seen++;
      bus.i_penable = 1'b1;
      step();
      if (bus.o_pready) seen++;
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.o_pready) seen++;
      end
      chk("abort_no_pready", 32'(seen), 32'd0);
      chk("abort_cnt", 32'(bus.o_xfer_cnt), 32'(mdl_cnt));
      model(1'b0, 12'h060, 32'h0, 4'h0, erd, eer);
      run("abort_readback", 1'b0, 12'h060, 32'h0, 4'h0, 1'b0, erd, eer, mdl_cnt);
`endif

      // Randomized traffic, with gaps, back-to-back and scrambled ACCESS inputs
      for (int i = 0; i < 300; i++) begin
         logic [31:0] wd;
         logic [3:0]  st;
         wr  = 1'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = {6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else if (sel == 1) a = 12'($urandom_range(DEPTH * 4, 4095));
         else               a = {2'b00, 8'($urandom_range(0, 15)), 2'b00};
         wd = $urandom;
         st = 4'($urandom);
         model(wr, a, wd, st, erd, eer);
         run("rand", wr, a, wd, st, 1'($urandom), erd, eer, mdl_cnt);
         repeat ($urandom_range(0, 2)) step();
      end

      // Reset mid-transfer drops the pending write
      model(1'b1, 12'h050, 32'h0BADF00D, 4'hF, erd, eer);
      run("pre_rst_wr", 1'b1, 12'h050, 32'h0BADF00D, 4'hF, 1'b0, erd, eer, mdl_cnt);
      bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
      bus.i_paddr = 12'h050; bus.i_pwdata = 32'h5555AAAA; bus.i_pstrb = 4'hF;
      step();
      bus.i_penable = 1'b1;
      _nreset = 1'b0;
      #1;
      chk("midrst_pready",   32'(bus.o_pready),   32'd0);
      chk("midrst_prdata",   bus.o_prdata,        32'd0);
      chk("midrst_pslverr",  32'(bus.o_pslverr),  32'd0);
      chk("midrst_prot_err", 32'(bus.o_prot_err), 32'd0);
      chk("midrst_xfer_cnt", 32'(bus.o_xfer_cnt), 32'd0);
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      step();
      _nreset = 1'b1;
      mdl_cnt = 0;
      step();
      run("post_rst_rd", 1'b0, 12'h050, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0, 1);
      mdl_cnt = 1;

      // 4096 completions since reset: counter wraps to 0
      for (int i = 0; i < 4095; i++) begin
         logic [31:0] rd;
         bit          er;
         int          lat;
         logic [31:0] wd;
         a  = {2'b00, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
         wd = $urandom;
         model(1'b1, a, wd, 4'hF, erd, eer);
         xfer(1'b1, a, wd, 4'hF, 1'b0, rd, er, lat);
         if (i == 4093) chk("wrap_cnt_4095", 32'(bus.o_xfer_cnt), 32'd4095);
      end
      chk("wrap_cnt_zero", 32'(bus.o_xfer_cnt), 32'd0);
      chk("wrap_cnt_model", 32'(bus.o_xfer_cnt), 32'(mdl_cnt));

      // Read back a few words written during the wrap run
      for (int i = 0; i < 8; i++) begin
         a = {2'b00, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
         model(1'b0, a, 32'h0, 4'h0, erd, eer);
         run("final_rd", 1'b0, a, 32'h0, 4'h0, 1'b1, erd, eer, mdl_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
